// File: rtl/an_fix_sched_n37_4x4_if.sv
// Bus bundle for an_fix_sched_n37_4x4.
// Groups the block-in handshake, the shared-decoder port and the block-out
// handshake. The slave modport is the scheduler's view and the master
// modport is the view of the surrounding logic (lanes, decoder, consumer).
//   in_*  : one 4x4 block of Barrett results, lane i at [i*W +: W]
//   dec_* : one lane at a time to/from the shared an_decoder_n37
//   out_* : corrected block plus fix mask, fix count and uncorrected flag
interface an_fix_sched_n37_4x4_if #(
  parameter int LANES = 16,
  parameter int CW_W  = 18,
  parameter int MSG_W = 13,
  parameter int RES_W = 6
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*MSG_W-1:0] in_q;
  logic [LANES*RES_W-1:0] in_r;
  logic [LANES*CW_W-1:0]  in_recv;
  logic [LANES-1:0]       in_err;

  logic [CW_W-1:0]        dec_codeword;
  logic [RES_W-1:0]       dec_residue;
  logic [3:0]             dec_lane;
  logic                   dec_en;
  logic [MSG_W-1:0]       dec_message;

  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*MSG_W-1:0] out_msg;
  logic [LANES-1:0]       out_fix_mask;
  logic [4:0]             out_fix_cnt;
  logic                   out_uncorr;

  modport slave (
    input  in_valid, in_q, in_r, in_recv, in_err, dec_message, out_ready,
    output in_ready, dec_codeword, dec_residue, dec_lane, dec_en,
           out_valid, out_msg, out_fix_mask, out_fix_cnt, out_uncorr
  );

  modport master (
    output in_valid, in_q, in_r, in_recv, in_err, dec_message, out_ready,
    input  in_ready, dec_codeword, dec_residue, dec_lane, dec_en,
           out_valid, out_msg, out_fix_mask, out_fix_cnt, out_uncorr
  );
endinterface

// File: rtl/an_fix_sched_n37_4x4.sv
// an_fix_sched_n37_4x4: buffers one 4x4 n37 block and corrects every flagged
// lane serially through a single shared an_decoder_n37, lowest lane first,
// one lane per cycle, up to MAX_FIX lanes per block.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; drops any in-flight block
//   bus   : an_fix_sched_n37_4x4_if.slave (in_*, dec_*, out_* groups)

// Per-lane storage: Barrett quotient (becomes the output message), residue
// and received codeword. A fix overwrites the message with the decoder result.
module an_fix_sched_n37_4x4_lane #(
  parameter int CW_W  = 18,
  parameter int MSG_W = 13,
  parameter int RES_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             fix,
  input  logic [MSG_W-1:0] q_in,
  input  logic [RES_W-1:0] r_in,
  input  logic [CW_W-1:0]  recv_in,
  input  logic [MSG_W-1:0] dec_msg,
  output logic [MSG_W-1:0] msg,
  output logic [RES_W-1:0] r,
  output logic [CW_W-1:0]  recv
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg  <= '0;
      r    <= '0;
      recv <= '0;
    end else if (load) begin
      msg  <= q_in;
      r    <= r_in;
      recv <= recv_in;
    end else if (fix) begin
      msg  <= dec_msg;
    end
  end
endmodule

module an_fix_sched_n37_4x4 #(
  parameter int LANES   = 16,
  parameter int CW_W    = 18,
  parameter int MSG_W   = 13,
  parameter int RES_W   = 6,
  parameter int MAX_FIX = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  an_fix_sched_n37_4x4_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_FIX, S_DONE} state_t;

  state_t state, state_nxt;

  logic [LANES-1:0][MSG_W-1:0] q_arr, msg_arr;
  logic [LANES-1:0][RES_W-1:0] r_in_arr, r_arr;
  logic [LANES-1:0][CW_W-1:0]  recv_in_arr, recv_arr;

  logic [LANES-1:0] pend, pend_nxt, fix_mask, onehot;
  logic [4:0]       fix_cnt, cnt_nxt;
  logic             uncorr;
  logic [3:0]       sel_lane;
  logic             accept, in_fix, fix_exit;

  assign q_arr       = bus.in_q;
  assign r_in_arr    = bus.in_r;
  assign recv_in_arr = bus.in_recv;

  assign accept = bus.in_valid && (state == S_IDLE);
  assign in_fix = (state == S_FIX);

  // Lowest pending lane wins; scanning high-to-low leaves the lowest set bit.
  always_comb begin
    sel_lane = '0;
    onehot   = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (pend[i]) begin
        sel_lane  = 4'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign pend_nxt = pend & ~onehot;
  assign cnt_nxt  = fix_cnt + 5'd1;
  assign fix_exit = (pend_nxt == '0) || (cnt_nxt == 5'(MAX_FIX));

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      an_fix_sched_n37_4x4_lane #(
        .CW_W  (CW_W),
        .MSG_W (MSG_W),
        .RES_W (RES_W)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .fix     (in_fix && onehot[g]),
        .q_in    (q_arr[g]),
        .r_in    (r_in_arr[g]),
        .recv_in (recv_in_arr[g]),
        .dec_msg (bus.dec_message),
        .msg     (msg_arr[g]),
        .r       (r_arr[g]),
        .recv    (recv_arr[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.dec_en       = 1'b0;
    bus.dec_lane     = '0;
    bus.dec_codeword = '0;
    bus.dec_residue  = '0;
    case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = (bus.in_err != '0) ? S_FIX : S_DONE;
      end
      S_FIX: begin
        bus.dec_en       = 1'b1;
        bus.dec_lane     = sel_lane;
        bus.dec_codeword = recv_arr[sel_lane];
        bus.dec_residue  = r_arr[sel_lane];
        if (fix_exit) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      fix_mask <= '0;
      fix_cnt  <= '0;
      uncorr   <= 1'b0;
    end else if (accept) begin
      pend     <= bus.in_err;
      fix_mask <= '0;
      fix_cnt  <= '0;
      uncorr   <= 1'b0;
    end else if (in_fix) begin
      pend     <= pend_nxt;
      fix_mask <= fix_mask | onehot;
      fix_cnt  <= cnt_nxt;
      // Leaving on the cap with lanes still pending: they keep Barrett q.
      if (fix_exit) uncorr <= (pend_nxt != '0);
    end
  end

  assign bus.out_msg      = msg_arr;
  assign bus.out_fix_mask = fix_mask;
  assign bus.out_fix_cnt  = fix_cnt;
  assign bus.out_uncorr   = uncorr;
endmodule

// File: tb/tb_an_fix_sched_n37_4x4.sv
// Bench for an_fix_sched_n37_4x4. Two instances: u_a with MAX_FIX=16 and
// u_b with MAX_FIX=2; sel routes the shared stimulus and observation to one.
// Each instance sees a behavioural decoder returning codeword/37.
module tb_an_fix_sched_n37_4x4;
  localparam int LANES = 16, CW_W = 18, MSG_W = 13, RES_W = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  always #5 clk = ~clk;

  logic                   v_valid, v_oready;
  logic [LANES*MSG_W-1:0] v_q;
  logic [LANES*RES_W-1:0] v_r;
  logic [LANES*CW_W-1:0]  v_recv;
  logic [LANES-1:0]       v_err;

  an_fix_sched_n37_4x4_if #(.LANES(LANES), .CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W)) ia ();
  an_fix_sched_n37_4x4_if #(.LANES(LANES), .CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W)) ib ();

  an_fix_sched_n37_4x4 #(.LANES(LANES), .CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W), .MAX_FIX(16))
    u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  an_fix_sched_n37_4x4 #(.LANES(LANES), .CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W), .MAX_FIX(2))
    u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  assign ia.in_valid    = v_valid & ~sel;
  assign ib.in_valid    = v_valid & sel;
  assign ia.out_ready   = v_oready & ~sel;
  assign ib.out_ready   = v_oready & sel;
  assign ia.in_q        = v_q;
  assign ib.in_q        = v_q;
  assign ia.in_r        = v_r;
  assign ib.in_r        = v_r;
  assign ia.in_recv     = v_recv;
  assign ib.in_recv     = v_recv;
  assign ia.in_err      = v_err;
  assign ib.in_err      = v_err;
  assign ia.dec_message = MSG_W'(ia.dec_codeword / 18'd37);
  assign ib.dec_message = MSG_W'(ib.dec_codeword / 18'd37);

  logic                   o_in_ready, o_out_valid, o_dec_en, o_uncorr;
  logic [3:0]             o_dec_lane;
  logic [CW_W-1:0]        o_dec_cw;
  logic [RES_W-1:0]       o_dec_res;
  logic [LANES*MSG_W-1:0] o_msg;
  logic [LANES-1:0]       o_mask;
  logic [4:0]             o_cnt;

  always_comb begin
    o_in_ready  = sel ? ib.in_ready     : ia.in_ready;
    o_out_valid = sel ? ib.out_valid    : ia.out_valid;
    o_dec_en    = sel ? ib.dec_en       : ia.dec_en;
    o_dec_lane  = sel ? ib.dec_lane     : ia.dec_lane;
    o_dec_cw    = sel ? ib.dec_codeword : ia.dec_codeword;
    o_dec_res   = sel ? ib.dec_residue  : ia.dec_residue;
    o_msg       = sel ? ib.out_msg      : ia.out_msg;
    o_mask      = sel ? ib.out_fix_mask : ia.out_fix_mask;
    o_cnt       = sel ? ib.out_fix_cnt  : ia.out_fix_cnt;
    o_uncorr    = sel ? ib.out_uncorr   : ia.out_uncorr;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_idle_dec(input string tag);
    chk({tag, "_dec_en"},   256'(o_dec_en),   256'(0));
    chk({tag, "_dec_lane"}, 256'(o_dec_lane), 256'(0));
    chk({tag, "_dec_cw"},   256'(o_dec_cw),   256'(0));
    chk({tag, "_dec_res"},  256'(o_dec_res),  256'(0));
  endtask

  task automatic rand_block(output logic [LANES*MSG_W-1:0] q, output logic [LANES*RES_W-1:0] r,
                            output logic [LANES*CW_W-1:0] rc, output logic [LANES-1:0] e);
    int mode;
    for (int i = 0; i < LANES; i++) begin
      q[i*MSG_W +: MSG_W] = MSG_W'($urandom);
      r[i*RES_W +: RES_W] = RES_W'($urandom);
      rc[i*CW_W +: CW_W]  = CW_W'($urandom);
    end
    mode = int'($urandom_range(0, 3));
    case (mode)
      0:       e = '0;
      1:       e = '1;
      2:       e = LANES'($urandom);
      default: begin e = '0; e[$urandom_range(0, LANES-1)] = 1'b1; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the output handshake,
  // with v_valid still high so the next call's block is the pending one.
  task automatic run_block(input logic [LANES*MSG_W-1:0] q, input logic [LANES*RES_W-1:0] r,
                           input logic [LANES*CW_W-1:0] rc, input logic [LANES-1:0] e,
                           input int hold);
    int order[$];
    int maxfix, n, l;
    logic [LANES*MSG_W-1:0] exp_msg;
    logic [LANES-1:0] exp_mask;
    logic exp_unc;

    maxfix = sel ? 2 : 16;
    order = {};
    for (int i = 0; i < LANES; i++) if (e[i]) order.push_back(i);
    n = (order.size() > maxfix) ? maxfix : order.size();
    exp_msg  = q;
    exp_mask = '0;
    for (int j = 0; j < n; j++) begin
      l = order[j];
      exp_msg[l*MSG_W +: MSG_W] = MSG_W'(rc[l*CW_W +: CW_W] / 37);
      exp_mask[l] = 1'b1;
    end
    exp_unc = (order.size() > maxfix);

    v_q = q; v_r = r; v_recv = rc; v_err = e;
    v_valid = 1'b1; v_oready = 1'b0;
    chk("acc_in_ready", 256'(o_in_ready), 256'(1));
    @(posedge clk); @(negedge clk);
    for (int j = 0; j < n; j++) begin
      l = order[j];
      chk("fix_dec_en",    256'(o_dec_en),    256'(1));
      chk("fix_dec_lane",  256'(o_dec_lane),  256'(l));
      chk("fix_dec_cw",    256'(o_dec_cw),    256'(rc[l*CW_W +: CW_W]));
      chk("fix_dec_res",   256'(o_dec_res),   256'(r[l*RES_W +: RES_W]));
      chk("fix_out_valid", 256'(o_out_valid), 256'(0));
      chk("fix_in_ready",  256'(o_in_ready),  256'(0));
      @(posedge clk); @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      chk("done_out_valid", 256'(o_out_valid), 256'(1));
      chk("done_in_ready",  256'(o_in_ready),  256'(0));
      chk("done_msg",       256'(o_msg),       256'(exp_msg));
      chk("done_mask",      256'(o_mask),      256'(exp_mask));
      chk("done_cnt",       256'(o_cnt),       256'(n));
      chk("done_uncorr",    256'(o_uncorr),    256'(exp_unc));
      chk_idle_dec("done");
      if (h < hold) begin @(posedge clk); @(negedge clk); end
    end
    v_oready = 1'b1;
    @(posedge clk); @(negedge clk);
    v_oready = 1'b0;
    chk("post_out_valid", 256'(o_out_valid), 256'(0));
    chk("post_in_ready",  256'(o_in_ready),  256'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [LANES*MSG_W-1:0] q;
    logic [LANES*RES_W-1:0] r;
    logic [LANES*CW_W-1:0]  rc;
    logic [LANES-1:0]       e;

    sel = 1'b0; rst_n = 1'b0;
    v_valid = 1'b0; v_oready = 1'b0; v_q = '0; v_r = '0; v_recv = '0; v_err = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  256'(o_in_ready),  256'(1));
    chk("rst_out_valid", 256'(o_out_valid), 256'(0));
    chk("rst_msg",       256'(o_msg),       256'(0));
    chk("rst_mask",      256'(o_mask),      256'(0));
    chk("rst_cnt",       256'(o_cnt),       256'(0));
    chk("rst_uncorr",    256'(o_uncorr),    256'(0));
    chk_idle_dec("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Clean block, lane i carries q=i.
    rand_block(q, r, rc, e);
    for (int i = 0; i < LANES; i++) q[i*MSG_W +: MSG_W] = MSG_W'(i);
    run_block(q, r, rc, '0, 0);

    // Single error on lane 5, codeword 37*100+5.
    rc[5*CW_W +: CW_W] = 18'd3705;
    run_block(q, r, rc, 16'h0020, 0);

    // Lanes 0, 7, 15.
    run_block(q, r, rc, 16'h8081, 0);

    // Backpressure with a pending in_valid held through DONE.
    rand_block(q, r, rc, e);
    run_block(q, r, rc, 16'h0312, 5);

    repeat (20) begin
      rand_block(q, r, rc, e);
      run_block(q, r, rc, e, int'($urandom_range(0, 3)));
    end

    // Reset during the third FIX cycle of an all-lanes block.
    rand_block(q, r, rc, e);
    v_q = q; v_r = r; v_recv = rc; v_err = '1; v_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    v_valid = 1'b0;
    chk("mid_fix_lane", 256'(o_dec_lane), 256'(2));
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 256'(o_out_valid), 256'(0));
    chk("mrst_msg",       256'(o_msg),       256'(0));
    chk("mrst_mask",      256'(o_mask),      256'(0));
    chk("mrst_cnt",       256'(o_cnt),       256'(0));
    chk("mrst_uncorr",    256'(o_uncorr),    256'(0));
    chk_idle_dec("mrst");
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_in_ready", 256'(o_in_ready), 256'(1));
    rand_block(q, r, rc, e);
    run_block(q, r, rc, 16'h00F0, 1);

    // Switch to the MAX_FIX=2 instance.
    v_valid = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    rand_block(q, r, rc, e);
    run_block(q, r, rc, 16'h8081, 0);
    repeat (8) begin
      rand_block(q, r, rc, e);
      run_block(q, r, rc, e, int'($urandom_range(0, 2)));
    end
    v_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/an_fix_sched_n37_4x4.md
# an_fix_sched_n37_4x4

Time-multiplexing scheduler that shares one `an_decoder_n37` instance across the 16 Barrett lanes of a 4x4 n37 block. The combinational 4x4 path corrects only the single highest-priority erroneous lane. This block instead buffers a whole 4x4 block, then corrects every flagged lane serially, one lane per cycle, through the shared decoder. It sits between the 16 `barrett_n37` lane outputs and the downstream consumer, with a valid/ready handshake on each side.

## Interface
- `LANES`, 16: lanes per block; a fixed 4x4 array, lane index = row*4 + col.
- `CW_W`, 18: received codeword width.
- `MSG_W`, 13: message / quotient width.
- `RES_W`, 6: Barrett residue width.
- `MAX_FIX`, 16: maximum lanes corrected per block, range 1..16.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  block present on the `in_*` buses.
- `in_ready`  out  1  block accepted when `in_valid & in_ready`.
- `in_q`  in  LANES*MSG_W  Barrett quotients; lane i occupies `[i*MSG_W +: MSG_W]`.
- `in_r`  in  LANES*RES_W  Barrett residues, same packing.
- `in_recv`  in  LANES*CW_W  received codewords, same packing.
- `in_err`  in  LANES  per-lane Barrett error flags.
- `dec_codeword`  out  CW_W  to the shared decoder `codeword`.
- `dec_residue`  out  RES_W  to the shared decoder `residue`.
- `dec_lane`  out  4  index of the lane currently being corrected.
- `dec_en`  out  1  high while a lane is presented to the decoder.
- `dec_message`  in  MSG_W  combinational decoder result.
- `out_valid`  out  1  corrected block available.
- `out_ready`  in  1  consumer accepts the block.
- `out_msg`  out  LANES*MSG_W  corrected messages, same packing as `in_q`.
- `out_fix_mask`  out  LANES  lanes replaced with decoder output.
- `out_fix_cnt`  out  5  popcount of `out_fix_mask`.
- `out_uncorr`  out  1  flagged lanes were left uncorrected because the `MAX_FIX` cap was reached.

## Operation
- FSM has three states: IDLE, FIX, DONE. Reset enters IDLE.
- **IDLE**
  - `in_ready`=1.
  - On accept, register `in_q` into the message buffer, `in_r` and `in_recv` into side buffers, and `in_err` into the pending mask. Clear the fix mask and fix count.
  - Next state is FIX if `in_err` != 0, otherwise DONE.
- **FIX**
  - Select the lowest-index set bit L of the pending mask.
  - Drive `dec_codeword`=recv[L], `dec_residue`=r[L], `dec_lane`=L, `dec_en`=1.
  - At the clock edge: msg[L] <= `dec_message`; clear pending[L]; set fix_mask[L]; increment fix count.
  - Leave FIX for DONE when the pending mask becomes zero after the update, or when the fix count reaches `MAX_FIX`.
  - On exit with pending != 0, set `out_uncorr`; those lanes keep their Barrett `q`.
- **DONE**
  - `out_valid`=1. All `out_*` buses come directly from registers and stay stable while `out_ready`=0.
  - On `out_ready`, go to IDLE.
- Outside FIX: `dec_en`=0, and `dec_codeword`, `dec_residue`, `dec_lane` are all 0.
- `in_ready` is high only in IDLE. There is no accept in the same cycle as the DONE handshake.
- `in_err` bits with no matching bad codeword are still passed to the decoder. The block does not check decoder results.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; `in_ready`=1; `out_valid`=0.
  - `out_msg`, `out_fix_mask`, `out_fix_cnt`, `out_uncorr` all 0.
  - `dec_*` outputs 0.
- Reset asserted mid-FIX or in DONE: the in-flight block is dropped with no output.
- Accept at edge T with k flagged lanes and k ≤ `MAX_FIX`:
  - FIX occupies the cycles after edges T+1 .. T+k.
  - `out_valid` rises after edge T+1+k. With k=0, `out_valid` rises after edge T+1.
- Accept with k > `MAX_FIX`: `out_valid` rises after edge T+1+`MAX_FIX`.
- Worst-case turnaround is 18 cycles: accept, 16 FIX cycles, DONE handshake.
- `dec_message` is sampled at the end of each FIX cycle. The decoder must be single-cycle combinational.
- Correction order is strictly ascending lane index.

## Test plan
- **Clean block.** `in_err`=0, `in_q` lane i = i. Required: `out_valid` one cycle after accept; `out_msg` lane i = i; `out_fix_mask`=0; `out_fix_cnt`=0; `dec_en` never high.
- **Single error.** `in_err`=16'h0020, `in_recv[5]`=3705 (37*100+5), bench decoder returns `codeword/37` (100). Required: exactly one FIX cycle with `dec_lane`=5 and `dec_codeword`=3705; `out_msg` lane 5 = 100; other lanes equal `in_q`; `out_fix_mask`=16'h0020; `out_fix_cnt`=1.
- **Multiple errors.** `in_err`=16'h8081 (lanes 0, 7, 15). Required: `dec_lane` sequence 0, 7, 15 on consecutive cycles; `out_valid` 4 cycles after accept; `out_fix_cnt`=3; `out_uncorr`=0.
- **Correction cap.** `MAX_FIX`=2, `in_err`=16'h8081. Required: only lanes 0 and 7 corrected; lane 15 keeps `in_q[15]`; `out_fix_mask`=16'h0081; `out_uncorr`=1.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles in DONE. Required: outputs stable; `in_ready`=0 throughout; a pending `in_valid` is accepted only in the cycle after the handshake.
- **Reset mid-FIX.** `in_err`=16'hFFFF, assert `rst_n`=0 during the 3rd FIX cycle. Required: all outputs zero immediately; `in_ready`=1 after reset; the next block processes normally.
